// File: rtl/seg_disp_pkg.sv
// Shared 7-segment display definitions: active-low segment patterns
// (bit6=a ... bit0=g) for digits 0-9, the blank pattern, and the BCD codes
// used for blank and undecodable readback. Shared with the display driver.
`timescale 1ns/1ps
package seg_disp_pkg;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam bcd_t BCD_BLANK = 4'hA;
   localparam bcd_t BCD_ERR   = 4'hF;

endpackage

// File: rtl/seg_scan_readback_if.sv
// Multiplexed display drive lines: active-low segments and active-low
// one-hot anodes. The display driver is the master; observers use slave.
`timescale 1ns/1ps
interface seg_scan_readback_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]            seg_in;
   logic [NUM_DIGITS-1:0] an_in;

   modport master (output seg_in, output an_in);
   modport slave  (input  seg_in, input  an_in);
endinterface

// File: rtl/seg_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder. Returns BCD_ERR with
// valid low for any pattern that is not a displayable digit.
// Build option SEG_BLANK_DETECT_EN: all-segments-off decodes to BCD_BLANK
// as a valid code instead of an error.
`timescale 1ns/1ps
module seg_to_bcd
   import seg_disp_pkg::*;
(
   input  logic [6:0] seg,
   output bcd_t       bcd,
   output logic       valid
);

   // Pattern lookup; anything unlisted is undecodable.
   always_comb begin
      // NOTE: outputs get defaults before the case so no path leaves them unassigned (no latch).
      bcd   = BCD_ERR;
      valid = 1'b0;
      case (seg)
         SEG_0: begin bcd = 4'd0; valid = 1'b1; end
         SEG_1: begin bcd = 4'd1; valid = 1'b1; end
         SEG_2: begin bcd = 4'd2; valid = 1'b1; end
         SEG_3: begin bcd = 4'd3; valid = 1'b1; end
         SEG_4: begin bcd = 4'd4; valid = 1'b1; end
         SEG_5: begin bcd = 4'd5; valid = 1'b1; end
         SEG_6: begin bcd = 4'd6; valid = 1'b1; end
         SEG_7: begin bcd = 4'd7; valid = 1'b1; end
         SEG_8: begin bcd = 4'd8; valid = 1'b1; end
         SEG_9: begin bcd = 4'd9; valid = 1'b1; end
`ifdef SEG_BLANK_DETECT_EN
         SEG_BLANK: begin bcd = BCD_BLANK; valid = 1'b1; end
`else
         SEG_BLANK: begin bcd = BCD_ERR;   valid = 1'b0; end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/seg_scan_readback.sv
// Passive readback of a multiplexed 7-segment display. Samples the drive
// lines, waits for each digit to be stable, decodes it back to BCD and
// publishes the whole number once every anode position has been seen.
// Build option SEG_BLANK_DETECT_EN (in seg_to_bcd): blank digits read back
// as 4'hA without a decode error.
`timescale 1ns/1ps
module seg_scan_readback
   import seg_disp_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
)(
   input  logic                    clk,
   input  logic                    reset,
   seg_scan_readback_if.slave      disp,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic                    frame_valid,
   output logic                    frame_done,
   output logic                    decode_err,
   output logic                    err_sticky
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

   logic [6:0]              s_seg, p_seg;
   logic [NUM_DIGITS-1:0]   s_an, p_an;
   logic [CNT_W-1:0]        cnt;
   logic                    armed;
   logic [NUM_DIGITS-1:0]   mask;
   logic [4*NUM_DIGITS-1:0] staging;

   logic [NUM_DIGITS-1:0]   an_low;
   logic                    an_onehot;
   logic                    hold;
   logic                    accept;
   logic                    mask_full;
   logic [IDX_W-1:0]        digit_idx;
   bcd_t                    dec_bcd;
   logic                    dec_valid;

   seg_to_bcd u_dec (
      .seg   (s_seg),
      .bcd   (dec_bcd),
      .valid (dec_valid)
   );

   // Stability and accept qualification from the two sample stages.
   always_comb begin
      an_low    = ~s_an;
      an_onehot = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
      hold      = (s_seg == p_seg) && (s_an == p_an) && an_onehot;
      accept    = hold && armed && (cnt == CNT_PRE);
      mask_full = &mask;
   end

   // OR-reduction one-hot to index; only meaningful while an_onehot holds.
   always_comb begin
      digit_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (an_low[i]) digit_idx = digit_idx | IDX_W'(i);
      end
   end

   // Two-stage sampling of the display lines; idle is blank with no anode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_seg <= '1;
         s_an  <= '1;
         p_seg <= '1;
         p_an  <= '1;
      end else begin
         // NOTE: non-blocking so every register sees the pre-edge values of its sources.
         s_seg <= disp.seg_in;
         s_an  <= disp.an_in;
         p_seg <= s_seg;
         p_an  <= s_an;
      end
   end

   // Saturating stability counter with a once-per-stretch accept arm.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         armed <= 1'b1;
      end else if (!hold) begin
         cnt   <= '0;
         armed <= 1'b1;
      end else begin
         if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
         if (accept)         armed <= 1'b0;
      end
   end

   // Staging digits and capture mask; an accept during completion starts the next frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: staging is small and reset-clear so a mid-frame reset discards it cleanly.
         staging <= '0;
         mask    <= '0;
      end else if (accept) begin
         staging[int'(digit_idx)*4 +: 4] <= dec_bcd;
         mask <= (mask_full ? '0 : mask) | an_low;
      end else if (mask_full) begin
         mask <= '0;
      end
   end

   // Frame publication and decode error reporting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits_out  <= '0;
         frame_valid <= 1'b0;
         frame_done  <= 1'b0;
         decode_err  <= 1'b0;
         err_sticky  <= 1'b0;
      end else begin
         frame_done <= mask_full;
         if (mask_full) begin
            digits_out  <= staging;
            frame_valid <= 1'b1;
         end
         decode_err <= accept && !dec_valid;
         if (accept && !dec_valid) err_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_readback.sv
// Directed bench for seg_scan_readback with NUM_DIGITS=4, STABLE_CYCLES=4.
// Segment patterns and expected frames are written out by hand.
`timescale 1ns/1ps
module tb_seg_scan_readback;

   localparam int ND = 4;
   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] digits_out;
   logic        frame_valid, frame_done, decode_err, err_sticky;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_cnt   = 0;
   int de_cnt   = 0;
   int fd_base, de_base;

   always #5 clk = ~clk;

   seg_scan_readback_if #(.NUM_DIGITS(ND)) disp ();

   seg_scan_readback #(
      .NUM_DIGITS    (ND),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .disp        (disp),
      .digits_out  (digits_out),
      .frame_valid (frame_valid),
      .frame_done  (frame_done),
      .decode_err  (decode_err),
      .err_sticky  (err_sticky)
   );

   // Pulse counters, sampled shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      if (frame_done) fd_cnt++;
      if (decode_err) de_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one anode/segment combination for n rising edges.
   task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
      @(negedge clk);
      disp.an_in  = an;
      disp.seg_in = seg;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic idle(input int n);
      drive(4'b1111, 7'b1111111, n);
   endtask

   task automatic do_reset();
      @(negedge clk);
      disp.an_in  = 4'b1111;
      disp.seg_in = 7'b1111111;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic snap();
      fd_base = fd_cnt;
      de_base = de_cnt;
   endtask

   initial begin
      reset       = 1'b1;
      disp.an_in  = 4'b1111;
      disp.seg_in = 7'b1111111;
      repeat (3) @(negedge clk);
      check("rst_digits", 32'(digits_out), 32'h0);
      check("rst_valid",  32'(frame_valid), 32'h0);
      check("rst_done",   32'(frame_done), 32'h0);
      check("rst_err",    32'(decode_err), 32'h0);
      check("rst_sticky", 32'(err_sticky), 32'h0);
      reset = 1'b0;
      idle(3);

      // 1: scan 1,2,3,4 with 6-cycle holds
      snap();
      drive(4'b1110, 7'b1001111, 6);
      drive(4'b1101, 7'b0010010, 6);
      drive(4'b1011, 7'b0000110, 6);
      drive(4'b0111, 7'b1001100, 6);
      idle(4);
      check("t1_digits", 32'(digits_out), 32'h4321);
      check("t1_valid",  32'(frame_valid), 32'h1);
      check("t1_done_n", 32'(fd_cnt - fd_base), 32'd1);
      check("t1_err_n",  32'(de_cnt - de_base), 32'd0);
      check("t1_sticky", 32'(err_sticky), 32'h0);

      // 2: holds too short to be accepted
      do_reset();
      snap();
      for (int r = 0; r < 2; r++) begin
         drive(4'b1110, 7'b1001111, 3);
         drive(4'b1101, 7'b0010010, 3);
         drive(4'b1011, 7'b0000110, 3);
         drive(4'b0111, 7'b1001100, 3);
      end
      idle(4);
      check("t2_done_n", 32'(fd_cnt - fd_base), 32'd0);
      check("t2_digits", 32'(digits_out), 32'h0);
      check("t2_valid",  32'(frame_valid), 32'h0);

      // 3a: digit 2 shows an undecodable pattern
      do_reset();
      snap();
      drive(4'b1110, 7'b1001111, 6);
      drive(4'b1101, 7'b0010010, 6);
      drive(4'b1011, 7'b1111110, 6);
      drive(4'b0111, 7'b1001100, 6);
      idle(6);
      check("t3_digits", 32'(digits_out), 32'h4F21);
      check("t3_err_n",  32'(de_cnt - de_base), 32'd1);
      check("t3_sticky", 32'(err_sticky), 32'h1);
      check("t3_done_n", 32'(fd_cnt - fd_base), 32'd1);

      // 3b: digit 2 blank (all segments off)
      do_reset();
      snap();
      drive(4'b1110, 7'b1001111, 6);
      drive(4'b1101, 7'b0010010, 6);
      drive(4'b1011, 7'b1111111, 6);
      drive(4'b0111, 7'b1001100, 6);
      idle(4);
`ifdef SEG_BLANK_DETECT_EN
      check("t3b_digits", 32'(digits_out), 32'h4A21);
      check("t3b_err_n",  32'(de_cnt - de_base), 32'd0);
      check("t3b_sticky", 32'(err_sticky), 32'h0);
`else
      check("t3b_digits", 32'(digits_out), 32'h4F21);
      check("t3b_err_n",  32'(de_cnt - de_base), 32'd1);
      check("t3b_sticky", 32'(err_sticky), 32'h1);
`endif

      // 4: two anodes low for 20 cycles between valid digits
      do_reset();
      snap();
      drive(4'b1110, 7'b1001111, 6);
      drive(4'b1100, 7'b0010010, 20);
      check("t4_glitch_done", 32'(fd_cnt - fd_base), 32'd0);
      check("t4_glitch_err",  32'(de_cnt - de_base), 32'd0);
      drive(4'b1101, 7'b0010010, 6);
      drive(4'b1011, 7'b0000110, 6);
      drive(4'b0111, 7'b1001100, 6);
      idle(4);
      check("t4_digits", 32'(digits_out), 32'h4321);
      check("t4_done_n", 32'(fd_cnt - fd_base), 32'd1);
      check("t4_err_n",  32'(de_cnt - de_base), 32'd0);

      // 5: digit 0 accepted as 5 then 7 before the frame completes
      do_reset();
      snap();
      drive(4'b1110, 7'b0100100, 6);
      drive(4'b1110, 7'b0001111, 6);
      drive(4'b1101, 7'b1001111, 6);
      drive(4'b1011, 7'b0010010, 6);
      drive(4'b0111, 7'b0000110, 6);
      idle(4);
      check("t5_digits", 32'(digits_out), 32'h3217);
      check("t5_done_n", 32'(fd_cnt - fd_base), 32'd1);

      // 6: reset after digits 0-1, then a full 9,8,7,6 scan (digits 2,3 first)
      drive(4'b1110, 7'b1001111, 6);
      drive(4'b1101, 7'b0010010, 6);
      do_reset();
      check("t6_rst_digits", 32'(digits_out), 32'h0);
      check("t6_rst_valid",  32'(frame_valid), 32'h0);
      snap();
      drive(4'b1011, 7'b0001111, 6);
      drive(4'b0111, 7'b0100000, 6);
      idle(4);
      check("t6_partial_done", 32'(fd_cnt - fd_base), 32'd0);
      drive(4'b1110, 7'b0000100, 6);
      drive(4'b1101, 7'b0000000, 6);
      idle(4);
      check("t6_digits", 32'(digits_out), 32'h6789);
      check("t6_done_n", 32'(fd_cnt - fd_base), 32'd1);
      check("t6_valid",  32'(frame_valid), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
